otter_io_timer: RTL and testbench
=================================

Name: otter_io_timer

Overview:
Memory-mapped timer/counter peripheral that responds to the OTTER CPU's IOBUS as a bus target. It decodes IOBUS_ADDR, accepts stores on IOBUS_WR, and returns read data on IOBUS_IN. It produces a level interrupt on INTR into the CPU when the counter matches a programmed compare value. It sits beside the other IO peripherals in the top-level wrapper.

Parameters:
BASE_ADDR, 32'h1100_0100, word-aligned base of the 5-register window
PRESCALE_W, 16, width of the prescaler reload register

Ports:
CLK  input  1  system clock, rising-edge
RESET_N  input  1  asynchronous active-low reset
IOBUS_ADDR  input  32  byte address from CPU memory stage
IOBUS_OUT  input  32  store data from CPU
IOBUS_WR  input  1  store strobe; valid for one cycle per store
IOBUS_IN  output  32  read data to CPU; combinational from address
INTR  output  1  level interrupt to CPU

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: PRESCALE_W bits, zero-extended on read.
  - 0x08 COUNT: 32 bits, read/write.
  - 0x0C COMPARE: 32 bits, read/write.
  - 0x10 STATUS: bit0 MATCH; write-1-to-clear; RO bit1 RUNNING.
- Decode: hit when IOBUS_ADDR[31:5] equals BASE_ADDR[31:5] and offset is ≤ 0x10. Address bits [1:0] are ignored.
- Reads: IOBUS_IN is combinational, zero wait states, because the CPU samples IO data at the MEM→WB edge. A miss or unmapped offset returns 32'h0.
- Writes: a register updates on the CLK edge where IOBUS_WR=1 and the address hits. Writes to unmapped offsets are ignored.
- Reset (async): all registers are 0, FSM is IDLE, prescaler count is 0, IOBUS_IN=0, INTR=0.
- Prescaler: while in RUN, it emits a one-cycle tick every PRESCALE+1 cycles. PRESCALE=0 gives a tick every cycle. Any PRESCALE write or entry into RUN restarts the prescaler at 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: when EN=1.
  - RUN→IDLE: when EN is written 0.
  - RUN→DONE: on a one-shot match (AUTO_RELOAD=0). At the same edge, hardware clears EN.
  - DONE→RUN: when EN is written 1.
  - DONE→IDLE: when EN=0 with no new write.
  - RUNNING=1 only in RUN.
- Count update on a tick:
  - If COUNT==COMPARE: set MATCH; COUNT becomes 0 when AUTO_RELOAD=1, otherwise COUNT holds.
  - Otherwise COUNT increments, modulo 2^32.
  - If COUNT > COMPARE, it wraps through 0xFFFFFFFF→0 and matches later.
  - COMPARE=0 with AUTO_RELOAD=1 matches on every tick.
- Match latency: MATCH is visible on IOBUS_IN and INTR the cycle after the tick edge.
- INTR = MATCH & IRQ_EN. It stays high until software clears MATCH or IRQ_EN.
- Simultaneous events:
  - A CPU write to COUNT on the same edge as a tick: the write wins and the tick is dropped.
  - A W1C of MATCH on the same edge as a new match: set wins, so MATCH stays 1.
  - A CTRL write setting EN on the same edge as a one-shot match: the write wins and the FSM stays in RUN.
- Reset mid-count: everything returns to reset values immediately, without waiting for a CLK edge.

Decomposition:
- Package otter_io_pkg holds:
  - register offset localparams (TMR_CTRL, TMR_PRESCALE, TMR_COUNT, TMR_COMPARE, TMR_STATUS);
  - CTRL bit-index localparams;
  - the enum tmr_state_t {IDLE, RUN, DONE}.
- One sub-module, otter_prescaler: inputs CLK, RESET_N, enable, restart, reload[PRESCALE_W-1:0]; output tick.

Test Plan:
- Reset then read all 5 offsets → every read returns 0; INTR=0; drive RESET_N low mid-count → COUNT reads 0 without a CLK edge.
- PRESCALE=3, COMPARE=5, CTRL=3'b111 → MATCH set and INTR high after the 6th tick (24 cycles after enable). COUNT reads 0 next cycle. The pattern repeats every 24 cycles until STATUS is written 1, which drops INTR.
- One-shot: CTRL=3'b101, COMPARE=2, PRESCALE=0 → after 3 ticks, MATCH=1, EN reads 0, RUNNING=0, COUNT holds at 2. Writing CTRL=3'b101 again → RUNNING=1.
- Wrap: write COUNT=32'hFFFF_FFFE, COMPARE=1, PRESCALE=0, enable → COUNT reads FFFF_FFFF, then 0, then 1, then MATCH.
- Collisions: W1C of STATUS on the same edge as a match → MATCH stays 1. Write COUNT=100 on a tick edge → COUNT reads 100, not 101.
- Decode: write address BASE_ADDR+0x20 or BASE_ADDR+0x1000 with data FFFF_FFFF → no register changes and IOBUS_IN=0. Write BASE_ADDR+0x0B → updates COUNT.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER IO timer peripheral.
// Holds the register byte offsets within the 5-register window, the CTRL and
// STATUS bit positions, and the timer FSM state type.
package otter_io_pkg;

  localparam logic [4:0] TMR_CTRL     = 5'h00;
  localparam logic [4:0] TMR_PRESCALE = 5'h04;
  localparam logic [4:0] TMR_COUNT    = 5'h08;
  localparam logic [4:0] TMR_COMPARE  = 5'h0C;
  localparam logic [4:0] TMR_STATUS   = 5'h10;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;

  localparam int unsigned STAT_MATCH   = 0;
  localparam int unsigned STAT_RUNNING = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tmr_state_t;

endpackage

// File: rtl/otter_prescaler.sv
// Prescaler for the IO timer.
// Emits a one-cycle tick every reload+1 cycles while enable is high.
// Ports:
//   CLK      - system clock, rising edge
//   RESET_N  - asynchronous active-low reset
//   enable   - count while high; held at 0 otherwise
//   restart  - return the divider to 0 (suppresses any tick this cycle)
//   reload   - terminal count; tick when the divider equals it
//   tick     - one-cycle count enable for the timer
module otter_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] reload,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_cnt;

  assign tick = enable & ~restart & (div_cnt == reload);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
    end else if (restart || !enable) begin
      div_cnt <= '0;
    end else if (div_cnt == reload) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped timer/counter on the OTTER IOBUS.
// Five registers at BASE_ADDR: CTRL, PRESCALE, COUNT, COMPARE, STATUS.
// Ports:
//   CLK        - system clock, rising edge
//   RESET_N    - asynchronous active-low reset
//   IOBUS_ADDR - byte address from the CPU memory stage
//   IOBUS_OUT  - store data from the CPU
//   IOBUS_WR   - one-cycle store strobe
//   IOBUS_IN   - read data to the CPU, combinational from the address
//   INTR       - level interrupt, MATCH & IRQ_EN
module otter_io_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  tmr_state_t            state, state_d;
  logic [2:0]            ctrl, ctrl_d;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count, count_d;
  logic [31:0]           compare;
  logic                  match, match_d;

  logic [4:0] off;
  logic       hit;
  logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic       tick, match_evt, oneshot_match, run_entry;

  // Byte lanes [1:0] are masked off rather than sliced away so every address bit is consumed.
  assign off = IOBUS_ADDR[4:0] & 5'b11100;
  assign hit = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]) && (off <= TMR_STATUS);

  assign wr_ctrl     = IOBUS_WR & hit & (off == TMR_CTRL);
  assign wr_prescale = IOBUS_WR & hit & (off == TMR_PRESCALE);
  assign wr_count    = IOBUS_WR & hit & (off == TMR_COUNT);
  assign wr_compare  = IOBUS_WR & hit & (off == TMR_COMPARE);
  assign wr_status   = IOBUS_WR & hit & (off == TMR_STATUS);

  assign run_entry = (state != RUN) && (state_d == RUN);

  otter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .enable  (state == RUN),
    .restart (wr_prescale | run_entry),
    .reload  (prescale),
    .tick    (tick)
  );

  // A CPU write to COUNT swallows a coincident tick, so no match can occur then.
  assign match_evt     = tick & ~wr_count & (count == compare);
  assign oneshot_match = match_evt & ~ctrl[CTRL_AUTO_RELOAD];

  always_comb begin
    ctrl_d = ctrl;
    if (wr_ctrl) begin
      ctrl_d = IOBUS_OUT[2:0];
    end else if (oneshot_match) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
  end

  always_comb begin
    count_d = count;
    if (wr_count) begin
      count_d = IOBUS_OUT;
    end else if (tick) begin
      if (count == compare) begin
        count_d = ctrl[CTRL_AUTO_RELOAD] ? '0 : count;
      end else begin
        count_d = count + 32'd1;
      end
    end
  end

  always_comb begin
    match_d = match;
    if (match_evt) begin
      match_d = 1'b1;
    end else if (wr_status && IOBUS_OUT[STAT_MATCH]) begin
      match_d = 1'b0;
    end
  end

  // EN as it will be after this edge: a CTRL write setting EN overrides the
  // hardware clear of a one-shot match and keeps the FSM in RUN.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (ctrl_d[CTRL_EN]) state_d = RUN;
      RUN:  if (!ctrl_d[CTRL_EN]) state_d = oneshot_match ? DONE : IDLE;
      DONE: state_d = ctrl_d[CTRL_EN] ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      ctrl     <= '0;
      prescale <= '0;
      count    <= '0;
      compare  <= '0;
      match    <= 1'b0;
    end else begin
      state   <= state_d;
      ctrl    <= ctrl_d;
      count   <= count_d;
      match   <= match_d;
      if (wr_prescale) prescale <= IOBUS_OUT[PRESCALE_W-1:0];
      if (wr_compare)  compare  <= IOBUS_OUT;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      case (off)
        TMR_CTRL:     IOBUS_IN = {29'd0, ctrl};
        TMR_PRESCALE: IOBUS_IN = 32'(prescale);
        TMR_COUNT:    IOBUS_IN = count;
        TMR_COMPARE:  IOBUS_IN = compare;
        TMR_STATUS:   IOBUS_IN = {30'd0, state == RUN, match};
        default:      IOBUS_IN = '0;
      endcase
    end
  end

  assign INTR = match & ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_otter_io_timer.sv
// Directed self-checking bench for otter_io_timer.
module tb_otter_io_timer;

  localparam logic [31:0] BASE   = 32'h1100_0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_PRE  = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_CMP  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  otter_io_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    IOBUS_ADDR = addr;
    #1;
    chk(tag, IOBUS_IN, exp);
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    chk(tag, {31'd0, INTR}, {31'd0, exp});
  endtask

  // Store lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    rd("rst_ctrl_in_reset", A_CTRL, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    cyc(1);
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_pre",  A_PRE,  32'h0);
    rd("rst_cnt",  A_CNT,  32'h0);
    rd("rst_cmp",  A_CMP,  32'h0);
    rd("rst_stat", A_STAT, 32'h0);
    chk_intr("rst_intr", 1'b0);

    // Asynchronous reset in the middle of counting
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd100);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h1);
    cyc(5);
    rd("mid_cnt_before", A_CNT, 32'd5);
    RESET_N = 1'b0;
    #1;
    rd("mid_cnt_async", A_CNT, 32'd0);
    rd("mid_stat_async", A_STAT, 32'd0);
    rd("mid_cmp_async", A_CMP, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    cyc(1);

    // Auto-reload with prescale 3: ticks every 4 cycles, match on 6th tick
    wr(A_PRE, 32'd3);
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    cyc(23);
    chk_intr("ar_intr_e23", 1'b0);
    rd("ar_cnt_e23", A_CNT, 32'd5);
    cyc(1);
    chk_intr("ar_intr_e24", 1'b1);
    rd("ar_stat_e24", A_STAT, 32'h3);
    rd("ar_cnt_e24", A_CNT, 32'd0);
    wr(A_STAT, 32'h1);
    chk_intr("ar_intr_clr", 1'b0);
    rd("ar_stat_clr", A_STAT, 32'h2);
    cyc(22);
    chk_intr("ar_intr_e47", 1'b0);
    cyc(1);
    chk_intr("ar_intr_e48", 1'b1);
    rd("ar_cnt_e48", A_CNT, 32'd0);
    wr(A_STAT, 32'h1);
    chk_intr("ar_intr_clr2", 1'b0);
    wr(A_CTRL, 32'h0);
    rd("ar_stat_idle", A_STAT, 32'h0);

    // One-shot, prescale 0
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CNT, 32'd0);
    wr(A_STAT, 32'h1);
    wr(A_CTRL, 32'h5);
    cyc(2);
    rd("os_cnt_e2", A_CNT, 32'd2);
    rd("os_stat_e2", A_STAT, 32'h2);
    cyc(1);
    rd("os_stat_e3", A_STAT, 32'h1);
    rd("os_ctrl_e3", A_CTRL, 32'h4);
    rd("os_cnt_e3", A_CNT, 32'd2);
    chk_intr("os_intr_e3", 1'b1);
    cyc(1);
    rd("os_stat_e4", A_STAT, 32'h1);
    rd("os_cnt_e4", A_CNT, 32'd2);
    wr(A_CTRL, 32'h5);
    rd("os_rerun_stat", A_STAT, 32'h3);
    cyc(1);
    rd("os_rerun_done", A_STAT, 32'h1);
    rd("os_rerun_ctrl", A_CTRL, 32'h4);

    // EN write on the same edge as a one-shot match keeps RUN
    wr(A_STAT, 32'h1);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h1);
    cyc(2);
    wr(A_CTRL, 32'h1);
    rd("col_en_stat", A_STAT, 32'h3);
    rd("col_en_ctrl", A_CTRL, 32'h1);
    cyc(1);
    rd("col_en_next", A_STAT, 32'h1);
    rd("col_en_ctrl2", A_CTRL, 32'h0);

    // W1C on the same edge as a new match: set wins
    wr(A_STAT, 32'h1);
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h3);
    cyc(3);
    rd("col_w1c_cnt", A_CNT, 32'd3);
    wr(A_STAT, 32'h1);
    rd("col_w1c_stat", A_STAT, 32'h3);
    rd("col_w1c_cnt0", A_CNT, 32'd0);
    wr(A_STAT, 32'h1);
    rd("col_w1c_clr", A_STAT, 32'h2);
    rd("col_w1c_cnt1", A_CNT, 32'd1);

    // COUNT write on a tick edge: write wins
    wr(A_CMP, 32'd1000);
    wr(A_CNT, 32'd100);
    rd("col_cnt_wr", A_CNT, 32'd100);
    cyc(1);
    rd("col_cnt_next", A_CNT, 32'd101);
    wr(A_CTRL, 32'h0);

    // Wrap through 0xFFFF_FFFF
    wr(A_STAT, 32'h1);
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd1);
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    cyc(1);
    rd("wrap_ffff", A_CNT, 32'hFFFF_FFFF);
    cyc(1);
    rd("wrap_0", A_CNT, 32'h0);
    cyc(1);
    rd("wrap_1", A_CNT, 32'h1);
    rd("wrap_nomatch", A_STAT, 32'h2);
    cyc(1);
    rd("wrap_match", A_STAT, 32'h1);
    rd("wrap_hold", A_CNT, 32'h1);

    // Decode
    cyc(1);
    wr(A_STAT, 32'h1);
    wr(A_PRE, 32'hFFFF_0007);
    wr(A_CMP, 32'h0000_00AA);
    wr(A_CNT, 32'h0000_0055);
    wr(A_CTRL, 32'h4);
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    wr(BASE + 32'h1000, 32'hFFFF_FFFF);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    rd("dec_rd_20", BASE + 32'h20, 32'h0);
    rd("dec_rd_1000", BASE + 32'h1000, 32'h0);
    rd("dec_rd_14", BASE + 32'h14, 32'h0);
    rd("dec_ctrl", A_CTRL, 32'h4);
    rd("dec_pre_zext", A_PRE, 32'h7);
    rd("dec_cnt", A_CNT, 32'h55);
    rd("dec_cmp", A_CMP, 32'hAA);
    rd("dec_stat", A_STAT, 32'h0);
    chk_intr("dec_intr", 1'b0);
    wr(BASE + 32'h0B, 32'h1234_5678);
    rd("dec_cnt_0b", A_CNT, 32'h1234_5678);
    rd("dec_cmp_0e", BASE + 32'h0E, 32'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
